store_unit: RTL and testbench

//   Write-side memory sequencer for the multicycle RISC-V datapath. Fetch and load paths read data memory; this block writes it.

---
 rtl/store_unit_if.sv | 31 +++
 rtl/store_unit.sv | 136 +++++++++++++
 tb/tb_store_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_unit_if.sv
// store_unit_if: store request/status and data-memory port bundle for store_unit.
// Ports: st_req/st_funct3/st_addr/st_data in, st_busy/st_done/st_err out,
//        mem_raddr/mem_waddr/mem_wdata/mem_wr out, mem_rdata in (slave = store unit view).
interface store_unit_if #(
  parameter int ADDR_W = 64
);
  logic              st_req;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [63:0]       st_data;
  logic              st_busy;
  logic              st_done;
  logic              st_err;
  logic [ADDR_W-1:0] mem_raddr;
  logic [63:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [63:0]       mem_wdata;
  logic              mem_wr;

  // Control unit and data memory side.
  modport master (
    output st_req, st_funct3, st_addr, st_data, mem_rdata,
    input  st_busy, st_done, st_err, mem_raddr, mem_waddr, mem_wdata, mem_wr
  );

  // Store unit side.
  modport slave (
    input  st_req, st_funct3, st_addr, st_data, mem_rdata,
    output st_busy, st_done, st_err, mem_raddr, mem_waddr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/store_unit.sv
// store_unit: SB/SH/SW/SD store sequencer onto a 64-bit-word data memory, read-modify-write for sub-doubleword stores.
// Ports: clk, reset (async, active-high), bus (store_unit_if.slave). SD writes in k+1, others in k+1+MEM_LAT; st_done one cycle after.
// Optional: `define STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW/SD with st_err; otherwise offsets are forced-aligned.
module store_unit #(
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  store_unit_if.slave  bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    size_q;   // funct3[1:0] of the captured store
  logic [2:0]    off_q;    // byte offset within the doubleword
  logic [63:0]   data_q;

  logic          illegal;
  logic          misaligned;
  logic [5:0]    shamt;
  logic [63:0]   lane_mask;
  logic [63:0]   lane_data;

  assign illegal = bus.st_funct3[2];

`ifdef STORE_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.st_funct3[1:0])
      2'b01:   misaligned = bus.st_addr[0];
      2'b10:   misaligned = (bus.st_addr[1:0] != 2'b00);
      2'b11:   misaligned = (bus.st_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Lane placement: offset bits below the access size are dropped, so
  // misaligned accesses land on the naturally aligned lanes.
  always_comb begin
    shamt     = 6'd0;
    lane_mask = '1;
    case (size_q)
      2'b00: begin
        shamt     = {off_q, 3'b000};
        lane_mask = 64'h0000_0000_0000_00FF << shamt;
      end
      2'b01: begin
        shamt     = {off_q[2:1], 1'b0, 3'b000};
        lane_mask = 64'h0000_0000_0000_FFFF << shamt;
      end
      2'b10: begin
        shamt     = {off_q[2], 2'b00, 3'b000};
        lane_mask = 64'h0000_0000_FFFF_FFFF << shamt;
      end
      default: begin
        shamt     = 6'd0;
        lane_mask = '1;
      end
    endcase
    lane_data = (data_q << shamt) & lane_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      size_q        <= '0;
      off_q         <= '0;
      data_q        <= '0;
      bus.st_busy   <= 1'b0;
      bus.st_done   <= 1'b0;
      bus.st_err    <= 1'b0;
      bus.mem_raddr <= '0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.st_req) begin
            size_q        <= bus.st_funct3[1:0];
            off_q         <= bus.st_addr[2:0];
            data_q        <= bus.st_data;
            bus.mem_raddr <= {bus.st_addr[ADDR_W-1:3], 3'b000};
            bus.mem_waddr <= {bus.st_addr[ADDR_W-1:3], 3'b000};
            bus.st_busy   <= 1'b1;
            if (illegal || misaligned) begin
              bus.st_done <= 1'b1;
              bus.st_err  <= 1'b1;
              state       <= DONE;
            end else if (bus.st_funct3[1:0] == 2'b11) begin
              // Full doubleword: no read needed.
              bus.mem_wdata <= bus.st_data;
              bus.mem_wr    <= 1'b1;
              state         <= WR;
            end else begin
              rd_cnt <= CW'(MEM_LAT - 1);
              state  <= RD;
            end
          end
        end
        RD: begin
          if (rd_cnt == '0) begin
            // mem_wdata doubles as the merge buffer.
            bus.mem_wdata <= (bus.mem_rdata & ~lane_mask) | lane_data;
            bus.mem_wr    <= 1'b1;
            state         <= WR;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        WR: begin
          bus.mem_wr  <= 1'b0;
          bus.st_done <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          bus.st_done <= 1'b0;
          bus.st_err  <= 1'b0;
          bus.st_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [63:0] mem [0:31];

  store_unit_if #(.ADDR_W(64)) bus ();

  store_unit #(.ADDR_W(64), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory read: data for mem_raddr is available within the same cycle (latency 1).
  assign bus.mem_rdata = mem[bus.mem_raddr[7:3]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns 1 ns after that edge (cycle k+1).
  task automatic issue(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
    bus.st_req    = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = addr;
    bus.st_data   = data;
    tick();
    bus.st_req    = 1'b0;
  endtask

  // Runs one store and records when/what was observed (cycle 1 = k+1).
  task automatic do_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data,
                          output int wr_cyc, output int done_cyc, output int wr_cnt,
                          output logic [63:0] wdata, output logic [63:0] waddr, output logic err);
    wr_cyc = -1; done_cyc = -1; wr_cnt = 0; wdata = '0; waddr = '0; err = 1'b0;
    issue(f3, addr, data);
    for (int c = 1; c <= 10; c++) begin
      if (bus.mem_wr) begin
        wr_cnt++;
        wr_cyc = c;
        wdata  = bus.mem_wdata;
        waddr  = bus.mem_waddr;
      end
      if (bus.st_done) begin
        done_cyc = c;
        err      = bus.st_err;
      end
      if (!bus.st_busy) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.st_req = 1'b0; bus.st_funct3 = '0; bus.st_addr = '0; bus.st_data = '0;
    tick(); tick();
    n_checks++;
    if ({bus.st_busy, bus.st_done, bus.st_err, bus.mem_wr} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.st_busy, bus.st_done, bus.st_err, bus.mem_wr});
    end
    n_checks++;
    if ((bus.mem_raddr | bus.mem_waddr | bus.mem_wdata) !== 64'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h/%h/%h want 0", bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sd();
    issue(3'b011, 64'h10, 64'h1122334455667788);
    n_checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 64'h10 || bus.mem_wdata !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL sd_write_k1: got wr=%b addr=%h data=%h want 1/10/1122334455667788", bus.mem_wr, bus.mem_waddr, bus.mem_wdata);
    end
    n_checks++;
    if (bus.st_busy !== 1'b1 || bus.st_done !== 1'b0) begin
      n_fail++; $display("FAIL sd_busy_k1: got busy=%b done=%b want 1/0", bus.st_busy, bus.st_done);
    end
    tick();
    n_checks++;
    if (bus.st_done !== 1'b1 || bus.st_err !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL sd_done_k2: got done=%b err=%b wr=%b want 1/0/0", bus.st_done, bus.st_err, bus.mem_wr);
    end
    tick();
    n_checks++;
    if (bus.st_busy !== 1'b0 || bus.st_done !== 1'b0) begin
      n_fail++; $display("FAIL sd_idle_k3: got busy=%b done=%b want 0/0", bus.st_busy, bus.st_done);
    end
  endtask

  task automatic test_sb();
    mem[2] = 64'hFFFFFFFFFFFFFFFF;
    issue(3'b000, 64'h13, 64'h00000000000000AB);
    n_checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_raddr !== 64'h10 || bus.st_busy !== 1'b1) begin
      n_fail++; $display("FAIL sb_read_k1: got wr=%b raddr=%h busy=%b want 0/10/1", bus.mem_wr, bus.mem_raddr, bus.st_busy);
    end
    tick();
    n_checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 64'hFFFFFFFFABFFFFFF || bus.mem_waddr !== 64'h10) begin
      n_fail++; $display("FAIL sb_write_k2: got wr=%b data=%h addr=%h want 1/FFFFFFFFABFFFFFF/10", bus.mem_wr, bus.mem_wdata, bus.mem_waddr);
    end
    tick();
    n_checks++;
    if (bus.st_done !== 1'b1 || bus.mem_wr !== 1'b0 || bus.st_err !== 1'b0) begin
      n_fail++; $display("FAIL sb_done_k3: got done=%b wr=%b err=%b want 1/0/0", bus.st_done, bus.mem_wr, bus.st_err);
    end
    tick();
  endtask

  task automatic test_sh_sw();
    int wc, dc, cnt; logic [63:0] wd, wa; logic er;
    mem[2] = 64'h0;
    do_store(3'b001, 64'h16, 64'hBEEF, wc, dc, cnt, wd, wa, er);
    n_checks++;
    if (wd !== 64'hBEEF000000000000 || wc != 2 || dc != 3 || cnt != 1) begin
      n_fail++; $display("FAIL sh_merge: got data=%h wr@%0d done@%0d n=%0d want BEEF000000000000 2 3 1", wd, wc, dc, cnt);
    end
    mem[4] = 64'h0123456789ABCDEF;
    do_store(3'b010, 64'h24, 64'hDEADBEEF, wc, dc, cnt, wd, wa, er);
    n_checks++;
    if (wd !== 64'hDEADBEEF89ABCDEF || wa !== 64'h20 || wc != 2 || dc != 3) begin
      n_fail++; $display("FAIL sw_merge: got data=%h addr=%h wr@%0d done@%0d want DEADBEEF89ABCDEF 20 2 3", wd, wa, wc, dc);
    end
  endtask

  task automatic test_misalign();
    int wc, dc, cnt; logic [63:0] wd, wa; logic er;
    mem[2] = 64'h0;
    do_store(3'b001, 64'h11, 64'h1234, wc, dc, cnt, wd, wa, er);
`ifdef STORE_MISALIGN_TRAP_EN
    n_checks++;
    if (dc != 1 || er !== 1'b1 || cnt != 0) begin
      n_fail++; $display("FAIL misalign_trap: got done@%0d err=%b writes=%0d want 1 1 0", dc, er, cnt);
    end
`else
    n_checks++;
    if (wd !== 64'h0000000000001234 || er !== 1'b0 || cnt != 1 || dc != 3) begin
      n_fail++; $display("FAIL misalign_forced: got data=%h err=%b writes=%0d done@%0d want 1234 0 1 3", wd, er, cnt, dc);
    end
`endif
  endtask

  task automatic test_illegal();
    int wc, dc, cnt; logic [63:0] wd, wa; logic er;
    do_store(3'b100, 64'h10, 64'h55, wc, dc, cnt, wd, wa, er);
    n_checks++;
    if (dc != 1 || er !== 1'b1 || cnt != 0) begin
      n_fail++; $display("FAIL illegal_f3: got done@%0d err=%b writes=%0d want 1 1 0", dc, er, cnt);
    end
  endtask

  task automatic test_req_held();
    int cnt;
    cnt = 0;
    bus.st_req = 1'b1; bus.st_funct3 = 3'b011; bus.st_addr = 64'h18; bus.st_data = 64'hCAFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_wr) cnt++;
    end
    bus.st_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_wr) cnt++;
    end
    n_checks++;
    if (cnt != 1 || bus.st_busy !== 1'b0) begin
      n_fail++; $display("FAIL req_held: got writes=%0d busy=%b want 1 0", cnt, bus.st_busy);
    end
  endtask

  task automatic test_back_to_back();
    int wc, dc, cnt; logic [63:0] wd, wa; logic er;
    mem[3] = 64'h1111111111111111;
    do_store(3'b000, 64'h1F, 64'hC3, wc, dc, cnt, wd, wa, er);
    n_checks++;
    if (wd !== 64'hC311111111111111 || wa !== 64'h18) begin
      n_fail++; $display("FAIL sb_lane7: got data=%h addr=%h want C311111111111111 18", wd, wa);
    end
    do_store(3'b001, 64'h18, 64'hFFFFA5A5, wc, dc, cnt, wd, wa, er);
    n_checks++;
    if (wd !== 64'h111111111111A5A5 || cnt != 1) begin
      n_fail++; $display("FAIL sh_lane0: got data=%h writes=%0d want 111111111111A5A5 1", wd, cnt);
    end
  endtask

  task automatic test_reset_in_rd();
    int cnt; int wc, dc, wn; logic [63:0] wd, wa; logic er;
    cnt = 0;
    issue(3'b010, 64'h20, 64'h77);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.st_busy, bus.st_done, bus.st_err, bus.mem_wr} !== 4'b0000 ||
        (bus.mem_raddr | bus.mem_waddr | bus.mem_wdata) !== 64'h0) begin
      n_fail++; $display("FAIL reset_async: got flags=%b raddr=%h wdata=%h want 0", {bus.st_busy, bus.st_done, bus.st_err, bus.mem_wr}, bus.mem_raddr, bus.mem_wdata);
    end
    tick();
    if (bus.mem_wr) cnt++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_wr) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL reset_no_write: got writes=%0d want 0", cnt);
    end
    do_store(3'b011, 64'h30, 64'hA5A5A5A55A5A5A5A, wc, dc, wn, wd, wa, er);
    n_checks++;
    if (wd !== 64'hA5A5A5A55A5A5A5A || wa !== 64'h30 || wc != 1 || dc != 2 || er !== 1'b0) begin
      n_fail++; $display("FAIL sd_after_reset: got data=%h addr=%h wr@%0d done@%0d err=%b want A5A5A5A55A5A5A5A 30 1 2 0", wd, wa, wc, dc, er);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
    test_reset();
    test_sd();
    test_sb();
    test_sh_sw();
    test_misalign();
    test_illegal();
    test_req_held();
    test_back_to_back();
    test_reset_in_rd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
